// File: rtl/sid_env_pkg.sv
// rtl/sid_env_pkg.sv - shared envelope state encoding, constants and rectifier helper
package sid_env_pkg;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_HOLD    = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_t;

  typedef enum logic {
    GATE_OFF = 1'b0,
    GATE_ON  = 1'b1
  } gate_state_t;

  localparam logic [7:0] ENV_MAX    = 8'd254;
  localparam int         WIN_BITS   = 9;
  localparam logic [3:0] RATE_CLAMP = 4'd7;

  // Rates 8..15 behave like the slowest rate 7.
  function automatic logic [3:0] clamp_rate(input logic [3:0] rate);
    return (rate > RATE_CLAMP) ? RATE_CLAMP : rate;
  endfunction

  // One's-complement magnitude so -128 lands on 127 instead of wrapping; result is even, 0..254.
  function automatic logic [7:0] rectify(input logic [7:0] s);
    logic [6:0] m7;
    m7 = s[7] ? ~s[6:0] : s[6:0];
    return {m7, 1'b0};
  endfunction

endpackage

// File: rtl/sid_envelope_follower_if.sv
// rtl/sid_envelope_follower_if.sv - sample stream, controls and envelope outputs of the follower
interface sid_envelope_follower_if;
  import sid_env_pkg::*;

  logic [7:0]  sample_in;
  logic        sample_valid;
  logic [3:0]  attack_rate;
  logic [3:0]  release_rate;
  logic [3:0]  gate_on_level;
  logic [3:0]  gate_off_level;
  logic [15:0] prescaler;
  logic [7:0]  env_out;
  env_state_t  env_state;
  logic        gate_out;
  logic        gate_rise;

  modport master (
    output sample_in, sample_valid, attack_rate, release_rate,
    output gate_on_level, gate_off_level, prescaler,
    input  env_out, env_state, gate_out, gate_rise
  );

  modport slave (
    input  sample_in, sample_valid, attack_rate, release_rate,
    input  gate_on_level, gate_off_level, prescaler,
    output env_out, env_state, gate_out, gate_rise
  );

endinterface

// File: rtl/sid_rate_tick.sv
// rtl/sid_rate_tick.sv - power-of-2 rate tick from the shared prescaler
module sid_rate_tick
  import sid_env_pkg::*;
(
  input  logic [3:0]  rate,
  input  logic [15:0] prescaler,
  output logic        tick
);

  logic [3:0]  n;
  logic [15:0] mask;

  // Tick when prescaler[n+8:0] is all ones; bits above the window are forced high.
  always_comb begin
    n    = clamp_rate(rate);
    mask = '0;
    for (int i = 0; i < 16; i++) begin
      mask[i] = (i <= (int'(n) + WIN_BITS - 1));
    end
    tick = &(prescaler | ~mask);
  end

endmodule

// File: rtl/sid_envelope_follower.sv
// rtl/sid_envelope_follower.sv - peak-window envelope follower with hysteretic gate detect
module sid_envelope_follower
  import sid_env_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  sid_envelope_follower_if.slave  bus
);

  logic [7:0]  mag;
  logic        win_tick;
  logic        atk_tick;
  logic        rel_tick;
  logic [7:0]  peak_q;
  logic [7:0]  target_q;
  logic [7:0]  target_d;
  logic [7:0]  env_q;
  logic [7:0]  env_d;
  env_state_t  state_q;
  env_state_t  state_d;
  gate_state_t gate_q;
  logic        gate_rise_q;

  sid_rate_tick u_atk_tick (
    .rate      (bus.attack_rate),
    .prescaler (bus.prescaler),
    .tick      (atk_tick)
  );

  sid_rate_tick u_rel_tick (
    .rate      (bus.release_rate),
    .prescaler (bus.prescaler),
    .tick      (rel_tick)
  );

  // Rectify the incoming sample and detect the 512-clock window boundary.
  always_comb begin
    mag      = rectify(bus.sample_in);
    win_tick = &bus.prescaler[WIN_BITS-1:0];
  end

  // Next target, next env (stepping toward the old target) and the state they imply.
  always_comb begin
    target_d = target_q;
    if (win_tick) begin
      target_d = (bus.sample_valid && (mag > peak_q)) ? mag : peak_q;
    end

    env_d = env_q;
    if ((env_q < target_q) && atk_tick && (env_q < ENV_MAX)) begin
      env_d = env_q + 8'd1;
    end else if ((env_q > target_q) && rel_tick) begin
      env_d = env_q - 8'd1;
    end

    if ((env_d == 8'd0) && (target_d == 8'd0)) begin
      state_d = ENV_IDLE;
    end else if (env_d < target_d) begin
      state_d = ENV_ATTACK;
    end else if (env_d > target_d) begin
      state_d = ENV_RELEASE;
    end else begin
      state_d = ENV_HOLD;
    end
  end

  // Peak over the current window; a window boundary restarts it from this cycle's sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= 8'd0;
    end else if (win_tick) begin
      peak_q <= bus.sample_valid ? mag : 8'd0;
    end else if (bus.sample_valid && (mag > peak_q)) begin
      peak_q <= mag;
    end
  end

  // Target, envelope and state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q <= 8'd0;
      env_q    <= 8'd0;
      state_q  <= ENV_IDLE;
    end else begin
      target_q <= target_d;
      env_q    <= env_d;
      state_q  <= state_d;
    end
  end

  // Gate FSM with separate on/off thresholds; rise pulse marks the first gated cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q      <= GATE_OFF;
      gate_rise_q <= 1'b0;
    end else begin
      gate_rise_q <= 1'b0;
      case (gate_q)
        GATE_OFF: begin
          if ((bus.gate_on_level != 4'd0) && (env_q >= {bus.gate_on_level, 4'h0})) begin
            gate_q      <= GATE_ON;
            gate_rise_q <= 1'b1;
          end
        end
        GATE_ON: begin
          if (env_q < {bus.gate_off_level, 4'h0}) begin
            gate_q <= GATE_OFF;
          end
        end
      endcase
    end
  end

  assign bus.env_out   = env_q;
  assign bus.env_state = state_q;
  assign bus.gate_out  = (gate_q == GATE_ON);
  assign bus.gate_rise = gate_rise_q;

endmodule

// File: tb/tb_sid_envelope_follower.sv
// tb/tb_sid_envelope_follower.sv - scoreboard bench for the envelope follower
module tb_sid_envelope_follower;

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_ATK  = 2'd1;
  localparam logic [1:0]  S_HOLD = 2'd2;
  localparam logic [1:0]  S_REL  = 2'd3;
  // Prescaler is an input, so ticks are produced directly: no tick, window + rate 0, every rate.
  localparam logic [15:0] P_NONE = 16'h0000;
  localparam logic [15:0] P_WIN  = 16'h01FF;
  localparam logic [15:0] P_ALL  = 16'hFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sid_envelope_follower_if bus ();

  sid_envelope_follower dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] env;
    logic [1:0] st;
    logic       g;
    logic       r;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  exp_t mx;
  int   checks = 0;
  int   passed = 0;

  // Monitor: outputs settle after each posedge; compare one queued expectation per negedge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mx = sbq.pop_front();
      checks++;
      if (bus.env_out === mx.env && bus.env_state === mx.st &&
          bus.gate_out === mx.g && bus.gate_rise === mx.r) begin
        passed++;
      end else begin
        $display("FAIL %s: got env=%0d state=%0d gate=%0b rise=%0b, want env=%0d state=%0d gate=%0b rise=%0b",
                 mx.nm, bus.env_out, bus.env_state, bus.gate_out, bus.gate_rise,
                 mx.env, mx.st, mx.g, mx.r);
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] s, input logic [15:0] p, input string nm,
                     input logic [7:0] e, input logic [1:0] st, input logic g, input logic r);
    exp_t x;
    bus.sample_valid = v;
    bus.sample_in    = s;
    bus.prescaler    = p;
    @(posedge clk);
    x.env = e;
    x.st  = st;
    x.g   = g;
    x.r   = r;
    x.nm  = nm;
    sbq.push_back(x);
    #1;
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    cyc(1'b0, 8'h00, P_NONE, nm, 8'd0, S_IDLE, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // From a cleared follower: constant +127, one window to load target 254, then n attack steps.
  task automatic ramp_up(input int n, input string nm);
    int thr;
    thr = 16 * int'(bus.gate_on_level);
    cyc(1'b1, 8'h7F, P_NONE, {nm, "-peak"}, 8'd0, S_IDLE, 1'b0, 1'b0);
    cyc(1'b1, 8'h7F, P_WIN, {nm, "-target"}, 8'd0, S_ATK, 1'b0, 1'b0);
    for (int i = 1; i <= n; i++) begin
      cyc(1'b1, 8'h7F, P_WIN, nm, 8'(i), (i < 254) ? S_ATK : S_HOLD,
          (thr != 0) && (i >= thr + 1), (thr != 0) && (i == thr + 1));
    end
  endtask

  initial begin
    bus.sample_in      = 8'h00;
    bus.sample_valid   = 1'b0;
    bus.attack_rate    = 4'd0;
    bus.release_rate   = 4'd0;
    bus.gate_on_level  = 4'd8;
    bus.gate_off_level = 4'd4;
    bus.prescaler      = P_NONE;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset dominates even with a sample and every tick present.
    cyc(1'b1, 8'h7F, P_ALL, "reset", 8'd0, S_IDLE, 1'b0, 1'b0);
    rst = 1'b0;

    // Full attack to 254 with gate rising the cycle after env = 128.
    ramp_up(254, "ramp127");
    cyc(1'b1, 8'h7F, P_WIN, "hold254", 8'd254, S_HOLD, 1'b1, 1'b0);

    // -128 must keep target at 254 (no wrap to 0).
    cyc(1'b1, 8'h80, P_WIN, "neg128a", 8'd254, S_HOLD, 1'b1, 1'b0);
    cyc(1'b1, 8'h80, P_WIN, "neg128b", 8'd254, S_HOLD, 1'b1, 1'b0);

    // Release at rate 9 (clamped to 7): only a full 16-bit all-ones prescaler steps env.
    bus.release_rate = 4'd9;
    cyc(1'b1, 8'h00, P_WIN, "rel-flush", 8'd254, S_HOLD, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, P_WIN, "rel-target0", 8'd254, S_REL, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, P_WIN, "rel-notick", 8'd254, S_REL, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 16'h7FFF, "rel-rate6", 8'd254, S_REL, 1'b1, 1'b0);
    for (int i = 1; i <= 254; i++) begin
      cyc(1'b0, 8'h00, P_ALL, "release", 8'(254 - i), (i == 254) ? S_IDLE : S_REL,
          (i <= 191), 1'b0);
    end

    // gate_on_level 0 never asserts, even at full scale.
    do_reset("reset-g0");
    bus.gate_on_level = 4'd0;
    ramp_up(254, "gate0");
    do_reset("reset-mag");
    bus.gate_on_level = 4'd8;

    // -1 rectifies to 0, +1 to 2.
    cyc(1'b1, 8'hFF, P_WIN, "mag-1", 8'd0, S_IDLE, 1'b0, 1'b0);
    cyc(1'b1, 8'h01, P_WIN, "mag+1a", 8'd0, S_ATK, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, P_NONE, "mag+1b", 8'd0, S_ATK, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, P_WIN, "mag+1c", 8'd1, S_ATK, 1'b0, 1'b0);
    cyc(1'b1, 8'h01, P_WIN, "mag+1d", 8'd2, S_HOLD, 1'b0, 1'b0);
    cyc(1'b1, 8'h01, P_WIN, "mag+1e", 8'd2, S_HOLD, 1'b0, 1'b0);

    // Window edge: peak 40, boundary sample of mag 100 sets target 100 and seeds the next window.
    do_reset("reset-win");
    cyc(1'b1, 8'd20, P_NONE, "win-peak40", 8'd0, S_IDLE, 1'b0, 1'b0);
    cyc(1'b1, 8'd50, P_WIN, "win-edge", 8'd0, S_ATK, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, P_WIN, "win-carry", 8'd1, S_ATK, 1'b0, 1'b0);
    for (int i = 2; i <= 100; i++) begin
      cyc(1'b1, 8'd50, P_WIN, "win-ramp", 8'(i), (i < 100) ? S_ATK : S_HOLD, 1'b0, 1'b0);
    end
    cyc(1'b1, 8'd50, P_WIN, "win-hold", 8'd100, S_HOLD, 1'b0, 1'b0);

    // Mid-operation reset at env 150 with gate high, then a clean recovery.
    do_reset("reset-pre");
    ramp_up(150, "pre-reset");
    rst = 1'b1;
    cyc(1'b1, 8'h7F, P_WIN, "midreset", 8'd0, S_IDLE, 1'b0, 1'b0);
    rst = 1'b0;
    ramp_up(254, "recover");

    repeat (3) @(posedge clk);
    checks++;
    if (sbq.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL drain: %0d expectations left, want 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
